// File: rtl/glb_pkg.sv
// Shared types for the bias global-buffer loader: loader state encoding,
// lane count of a packed FIFO word and the tail lane-enable helper.
package glb_pkg;

    localparam int FIFO_WIDTH_DEF = 64;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int LANES          = FIFO_WIDTH_DEF / DATA_WIDTH_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    // Lanes below tail stay enabled; tail == 0 means the final word is full.
    function automatic logic [LANES-1:0] lane_enable(input logic [1:0] tail);
        logic [LANES-1:0] en;
        en = '1;
        if (tail != 2'b00) begin
            en = (LANES'(1) << tail) - LANES'(1);
        end
        return en;
    endfunction

endpackage

// File: rtl/bias_glb_loader.sv
// Pops packed bias words from the input FIFO and writes them bank-parallel
// into the bias GLB, zeroing the unused lanes of a partial final word.
//
// state | meaning
// IDLE  | waiting for start; num_bias sampled here only
// LOAD  | popping words while the FIFO has data and words remain
// FLUSH | final write in flight on the GLB port
// DONE  | one-cycle completion pulse, then back to IDLE
module bias_glb_loader
    import glb_pkg::*;
#(
    parameter int FIFO_WIDTH = 64,
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 384,
    parameter int ADDR       = $clog2(DEPTH)
) (
    input  logic                  core_clk,
    input  logic                  core_rst_n,
    input  logic                  start,
    input  logic [ADDR:0]         num_bias,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_dout,
    output logic                  fifo_re,
    output logic                  glb_we,
    output logic [ADDR-1:0]       glb_waddr,
    output logic [FIFO_WIDTH-1:0] glb_wdata,
    output logic                  busy,
    output logic                  done
);

    localparam int            CW      = ADDR - 1;
    localparam logic [ADDR:0] DEPTH_C = (ADDR+1)'(DEPTH);
    localparam logic [CW-1:0] ONE_W   = CW'(1);

    loader_state_t state, state_nxt;

    logic [CW-1:0]         words_total;
    logic [CW-1:0]         words_issued;
    logic [1:0]            tail;
    logic                  last_wr;
    logic [ADDR:0]         n_eff;
    logic [CW-1:0]         words_total_nxt;
    logic                  pop;
    logic                  last_pop;
    logic [LANES-1:0]      lane_en;
    logic [FIFO_WIDTH-1:0] wdata_mask;

    always_comb begin
        n_eff           = (num_bias > DEPTH_C) ? DEPTH_C : num_bias;
        words_total_nxt = n_eff[ADDR:2] + CW'(n_eff[1:0] != 2'b00);
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        last_pop  = 1'b0;
        busy      = (state != IDLE);
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_bias == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                pop      = !fifo_empty && (words_issued < words_total);
                last_pop = pop && (words_issued == (words_total - ONE_W));
                if (last_pop) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign fifo_re = pop;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            words_total  <= '0;
            words_issued <= '0;
            tail         <= '0;
            glb_we       <= 1'b0;
            glb_waddr    <= '0;
            last_wr      <= 1'b0;
        end else begin
            glb_we  <= pop;
            last_wr <= last_pop;
            if (state == IDLE && start) begin
                words_total  <= words_total_nxt;
                tail         <= n_eff[1:0];
                words_issued <= '0;
            end else if (pop) begin
                words_issued <= words_issued + ONE_W;
            end
            // Word index times four: one row per word across the four banks.
            if (pop) begin
                glb_waddr <= ADDR'({words_issued, 2'b00});
            end
        end
    end

    // FIFO data arrives the cycle after the pop, so it lines up with glb_we.
    always_comb begin
        lane_en    = last_wr ? lane_enable(tail) : '1;
        wdata_mask = '0;
        for (int k = 0; k < LANES; k++) begin
            wdata_mask[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{lane_en[k]}};
        end
    end

    assign glb_wdata = fifo_dout & wdata_mask;

endmodule

// File: doc/bias_glb_loader.md
# bias_glb_loader

Fills the bias global buffer from the off-chip input FIFO before a layer starts. It pops 64-bit FIFO words, each packing four 16-bit biases, and issues bank-parallel writes to the bias GLB. Lane k of a word (bits 16k+15:16k) lands in bank k at row waddr[ADDR-1:2]. The block sits between the bias input FIFO and the bias GLB write port. It reports busy/done to the top-level controller.

## Interface
- FIFO_WIDTH, 64, FIFO word width; must equal 4*DATA_WIDTH
- DATA_WIDTH, 16, bias width
- DEPTH, 384, GLB capacity in biases; multiple of 4
- ADDR, $clog2(DEPTH), GLB address width
- core_clk  in  1  core clock; all logic on rising edge
- core_rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- num_bias  in  ADDR+1  number of biases to load; sampled with start
- fifo_empty  in  1  input FIFO empty flag
- fifo_dout  in  FIFO_WIDTH  FIFO read data; valid the cycle after fifo_re
- fifo_re  out  1  FIFO pop; combinational from state/counters/fifo_empty
- glb_we  out  1  GLB write enable; registered
- glb_waddr  out  ADDR  GLB write address; registered; always a multiple of 4
- glb_wdata  out  FIFO_WIDTH  GLB write data; fifo_dout with tail lanes masked
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the load completes

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE → LOAD on start.
  - Latch n_eff = min(num_bias, DEPTH).
  - Latch words_total = ceil(n_eff/4), width ADDR-1.
  - Latch tail = n_eff mod 4.
  - Clear words_issued.
- IDLE → DONE on start with num_bias == 0. No FIFO pop and no GLB write.
- LOAD:
  - fifo_re = !fifo_empty && (words_issued < words_total).
  - Each pop increments words_issued.
  - When the pop with words_issued == words_total-1 occurs, go to FLUSH.
- FLUSH: one cycle, for the final write to complete. Then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Write pipeline:
  - glb_we <= fifo_re.
  - glb_waddr <= 4*(index of popped word); the first word goes to address 0.
  - glb_wdata is combinational from fifo_dout, aligned with glb_we.
- Tail masking: on the final word, if tail != 0, lanes tail..3 of glb_wdata are forced to 0. All other words pass unmodified.
- start while busy is ignored. num_bias is not re-sampled.
- fifo_empty in LOAD stalls the load: no pop, no write, state held. There is no timeout.
- Address never exceeds DEPTH-4 because of the clamp. There is no wrap-around.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, glb_we=0, glb_waddr=0, busy=0, done=0, all counters 0. fifo_re is 0 because state is IDLE.
- Start accepted at edge t0 → busy=1 from t0.
- With a non-empty FIFO, fifo_re is high in cycles t0 .. t0+W-1, where W = words_total.
- glb_we is high in cycles t0+1 .. t0+W.
- FLUSH coincides with the last glb_we cycle (t0+W). done pulses in cycle t0+W+1.
- busy falls with the return to IDLE at t0+W+2.
- Zero-length load: done pulses the cycle after start.
- Minimum gap between done and the next accepted start: 1 cycle (IDLE).
- Reset mid-load: all outputs return to reset values immediately. FIFO words already popped are lost, and no further write is issued. The controller must reflush the FIFO.
- Throughput: one word (4 biases) per cycle.

## Structure
- Shared package (glb_pkg): loader state enum (IDLE, LOAD, FLUSH, DONE) and LANES = FIFO_WIDTH/DATA_WIDTH = 4.
- Single flat module; no sub-module is needed.
- The tail mask is a 4-bit lane-enable derived from tail, expanded to FIFO_WIDTH.

## Test plan
- num_bias=8, FIFO never empty:
  - fifo_re high 2 cycles.
  - Writes at waddr 0 and 4 with unmodified data.
  - done at t0+3.
  - busy low at t0+4.
- num_bias=6, word1=0x1111_2222_3333_4444:
  - Second write at waddr 4 with glb_wdata=0x0000_0000_3333_4444.
  - First word unmasked.
- num_bias=12 with fifo_empty high for 3 cycles after the first pop:
  - No fifo_re/glb_we during the stall.
  - Writes at 0, 4, 8.
  - done 3 cycles later than the no-stall case.
- num_bias=0:
  - No fifo_re, no glb_we.
  - done pulses the cycle after start.
- num_bias=400 (clamped to 384):
  - Exactly 96 writes, last at waddr 380, no masking.
  - A start pulse during busy has no effect.
- core_rst_n low mid-load after 2 of 4 words:
  - glb_we, busy, glb_waddr drop to 0 asynchronously; no further writes.
  - A new start of 4 biases after reset writes waddr 0.
